pipelined_adder: RTL and testbench

// - Parametrised, pipelined multi-bit successor of the 1-bit full adder cell.
// - Adds two WIDTH-bit operands plus carry-in, one CHUNK (= WIDTH/STAGES) slice per stage.
// - The carry ripples stage-to-stage through registers.
// - Valid/ready handshake on both sides; sits between operand producers and neuron accumulators.
//

---
 rtl/pipelined_adder_if.sv | 48 ++++
 rtl/pipelined_adder.sv | 100 ++++++++++
 tb/tb_pipelined_adder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// Carries an extra sub bit when PIPELINED_ADDER_SUB_EN is defined.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef PIPELINED_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
`ifdef PIPELINED_ADDER_SUB_EN
        output sub,
`endif
        output in_valid,
        output a,
        output b,
        output cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  cout
    );

    modport slave (
`ifdef PIPELINED_ADDER_SUB_EN
        input  sub,
`endif
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output cout
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined ripple adder: one CHUNK slice per stage, carry registered between stages.
// Define PIPELINED_ADDER_SUB_EN to add a per-operation subtract control.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic              clk,
    input logic              rst,
    pipelined_adder_if.slave bus
);
    localparam int CHUNK = WIDTH / STAGES;

    if (WIDTH % STAGES != 0) begin : g_chk
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    logic             adv;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

    assign a_in = bus.a;
`ifdef PIPELINED_ADDER_SUB_EN
    // a - b as a + ~b + 1; cin is ignored when subtracting
    assign b_in = bus.sub ? ~bus.b : bus.b;
    assign c_in = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_in = bus.b;
    assign c_in = bus.cin;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int IW = WIDTH - k * CHUNK;
        localparam int SW = (k + 1) * CHUNK;

        logic [IW-1:0]  a_p;
        logic [IW-1:0]  b_p;
        logic           c_p;
        logic           v_p;
        logic [CHUNK:0] part;
        logic [SW-1:0]  s_nx;
        logic           v;
        logic           c;
        logic [SW-1:0]  s;

        if (k == 0) begin : g_src
            assign a_p  = a_in;
            assign b_p  = b_in;
            assign c_p  = c_in;
            assign v_p  = bus.in_valid;
            assign s_nx = part[CHUNK-1:0];
        end else begin : g_src
            assign a_p  = g_st[k-1].g_fwd.a_r;
            assign b_p  = g_st[k-1].g_fwd.b_r;
            assign c_p  = g_st[k-1].c;
            assign v_p  = g_st[k-1].v;
            assign s_nx = {part[CHUNK-1:0], g_st[k-1].s};
        end

        assign part = {1'b0, a_p[CHUNK-1:0]}
                    + {1'b0, b_p[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, c_p};

        // Data only loads on valid slots so the output holds across bubbles
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v <= 1'b0;
                c <= 1'b0;
                s <= '0;
            end else if (adv) begin
                v <= v_p;
                if (v_p) begin
                    c <= part[CHUNK];
                    s <= s_nx;
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [IW-CHUNK-1:0] a_r;
            logic [IW-CHUNK-1:0] b_r;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (adv && v_p) begin
                    a_r <= a_p[IW-1:CHUNK];
                    b_r <= b_p[IW-1:CHUNK];
                end
            end
        end
    end

    assign adv           = !g_st[STAGES-1].v | bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = g_st[STAGES-1].v;
    assign bus.sum       = g_st[STAGES-1].s;
    assign bus.cout      = g_st[STAGES-1].c;
endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4).
// Queue scoreboard; covers wrap, carry-in, streaming, bubbles, stall, reset, subtract.
module tb_pipelined_adder;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(W)) bus ();

    pipelined_adder #(
        .WIDTH (W),
        .STAGES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int         tests = 0;
    int         fails = 0;
    int         cyc_n = 0;
    int         run = 0;
    int         max_run = 0;
    logic [W:0] exp_q[$];
    int         tag_q[$];
    logic [W:0] last_out = '0;

    task automatic check(input string tag, input logic [W:0] obs,
                         input logic [W:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic ci, input logic sb);
        logic [W-1:0] nb;
        nb = ~b;
        if (sb) return {1'b0, a} + {1'b0, nb} + 17'd1;
        return {1'b0, a} + {1'b0, b} + {16'd0, ci};
    endfunction

    task automatic cyc(input logic iv, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic ci,
                       input logic sb, input logic ordy, input bit lat);
        logic [W:0] e;
        int         t;
        bus.in_valid  = iv;
        bus.a         = a;
        bus.b         = b;
        bus.cin       = ci;
`ifdef PIPELINED_ADDER_SUB_EN
        bus.sub       = sb;
`endif
        bus.out_ready = ordy;
        @(negedge clk);
        if (bus.out_valid) begin
            run++;
            if (run > max_run) max_run = run;
            if (!bus.out_ready) begin
                check("stall_in_ready", {16'd0, bus.in_ready}, 17'd0);
                if (exp_q.size() != 0)
                    check("stall_hold", {bus.cout, bus.sum}, exp_q[0]);
            end else if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL spurious_out: got %h want none",
                       {bus.cout, bus.sum});
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check("result", {bus.cout, bus.sum}, e);
                last_out = e;
                if (lat) check("latency", 17'(cyc_n - t), 17'd4);
            end
        end else begin
            run = 0;
            check("idle_hold", {bus.cout, bus.sum}, last_out);
        end
        if (iv && bus.in_ready) begin
            exp_q.push_back(model(a, b, ci, sb));
            tag_q.push_back(cyc_n);
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic idle(input int n, input logic ordy, input bit lat);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0, ordy, lat);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
`ifdef PIPELINED_ADDER_SUB_EN
        bus.sub       = 1'b0;
`endif
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {16'd0, bus.out_valid}, 17'd0);
        check("rst_result", {bus.cout, bus.sum}, 17'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {16'd0, bus.in_ready}, 17'd1);
        @(posedge clk);
        #1;

        // T1 wrap
        cyc(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(4, 1'b1, 1'b1);
        check("t1_value", last_out, 17'h10000);
        check("t1_drain", 17'(exp_q.size()), 17'd0);

        // T2 carry-in
        cyc(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(4, 1'b1, 1'b1);
        check("t2_value", last_out, 17'h05556);
        check("t2_drain", 17'(exp_q.size()), 17'd0);

        // Boundaries: zero, all-ones, chunk-crossing and long ripple
        cyc(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 16'h0FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(4, 1'b1, 1'b1);
        check("bnd_last", last_out, 17'h01000);
        check("bnd_drain", 17'(exp_q.size()), 17'd0);

        // T3 back-to-back stream
        max_run = 0;
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 16'($urandom), 16'($urandom), 1'($urandom),
                1'b0, 1'b1, 1'b1);
        idle(5, 1'b1, 1'b1);
        check("t3_run", 17'(max_run), 17'd8);
        check("t3_drain", 17'(exp_q.size()), 17'd0);

        // Bubbles keep their slots
        cyc(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 16'h00FF, 16'h0F01, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(5, 1'b1, 1'b1);
        check("bub_drain", 17'(exp_q.size()), 17'd0);

        // T4 stall: fill, hold off 3 cycles, release
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 16'($urandom), 16'($urandom), 1'($urandom),
                1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 16'h7777, 16'h7777, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_queued", 17'(exp_q.size()), 17'd4);
        idle(6, 1'b1, 1'b0);
        check("t4_drain", 17'(exp_q.size()), 17'd0);

        // T5 reset with work in flight
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_pre_valid", {16'd0, bus.out_valid}, 17'd1);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t5_out_valid", {16'd0, bus.out_valid}, 17'd0);
        check("t5_result", {bus.cout, bus.sum}, 17'd0);
        exp_q.delete();
        tag_q.delete();
        last_out = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6, 1'b1, 1'b1);
        cyc(1'b1, 16'h4000, 16'hC000, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(4, 1'b1, 1'b1);
        check("t5_new", last_out, 17'h10001);
        check("t5_drain", 17'(exp_q.size()), 17'd0);

`ifdef PIPELINED_ADDER_SUB_EN
        // T6 subtract, mixed with add
        cyc(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 16'h0007, 16'h0005, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b1, 1'b1);
        check("t6_sub_neg", last_out, 17'h0FFFE);
        idle(1, 1'b1, 1'b1);
        check("t6_sub_pos", last_out, 17'h10002);
        idle(1, 1'b1, 1'b1);
        check("t6_add", last_out, 17'h0000D);
        check("t6_drain", 17'(exp_q.size()), 17'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
